avalon_multi_timer: RTL

Parametrised multi-channel interval timer with an Avalon-MM slave port, the next generation of the system's single 16-bit-bus interval timer. It provides up to four independent down-counters of configurable width, each with one-shot or continuous mode, snapshot capture and timeout interrupt. An optional compare/PWM output per channel is also available. It sits on the lightweight HPS-to-FPGA bridge beside the other QSYS peripherals and drives a single combined `irq` line.

---
 rtl/avalon_multi_timer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: multi-channel Avalon-MM interval timer with snapshot, timeout IRQ and optional PWM (TIMER_PWM_EN)
module avalon_multi_timer #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 9999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);
    logic        wr;
    logic [31:0] rd_ch [4];
    logic [3:0]  irq_ch;
    logic [31:0] readdata_q, readdata_d;

    assign wr = chipselect && !write_n;

    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic             sel, we_stat, we_ctl, we_per, we_snap, tmo;
            logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
            logic             run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
            logic             reload_q, reload_d;
            logic [31:0]      cmp_rd;

            assign sel     = wr && (address[4:3] == 2'(c));
            assign we_stat = sel && (address[2:0] == 3'd0);
            assign we_ctl  = sel && (address[2:0] == 3'd1);
            assign we_per  = sel && (address[2:0] == 3'd2);
            assign we_snap = sel && (address[2:0] == 3'd3);
            assign tmo     = run_q && (cnt_q == '0);

            // Next state: PERIOD writes arm a force-reload that lands one edge later and beats START
            always_comb begin
                period_d = we_per ? writedata[CNT_W-1:0] : period_q;
                reload_d = we_per;
                snap_d   = we_snap ? cnt_q : snap_q;
                ito_d    = we_ctl ? writedata[0] : ito_q;
                cont_d   = we_ctl ? writedata[1] : cont_q;
                to_d     = tmo | (to_q & ~we_stat);
                cnt_d    = reload_q ? period_q : !run_q ? cnt_q : tmo ? period_q : cnt_q - CNT_W'(1);
                run_d    = run_q & ~(tmo & ~cont_q);
                if (we_ctl && writedata[3]) run_d = 1'b0;
                if (we_ctl && writedata[2]) run_d = 1'b1;
                if (reload_q) run_d = 1'b0;
            end

            // Channel state registers
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= CNT_W'(RESET_PERIOD);
                    period_q <= CNT_W'(RESET_PERIOD);
                    snap_q   <= '0;
                    run_q    <= 1'b0;
                    to_q     <= 1'b0;
                    ito_q    <= 1'b0;
                    cont_q   <= 1'b0;
                    reload_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    period_q <= period_d;
                    snap_q   <= snap_d;
                    run_q    <= run_d;
                    to_q     <= to_d;
                    ito_q    <= ito_d;
                    cont_q   <= cont_d;
                    reload_q <= reload_d;
                end
            end

`ifdef TIMER_PWM_EN
            logic [CNT_W-1:0] cmp_q, cmp_d;
            logic             pwm_q, pwm_d;

            // Compare threshold and registered compare output, one cycle behind the counter
            always_comb begin
                cmp_d = (sel && address[2:0] == 3'd4) ? writedata[CNT_W-1:0] : cmp_q;
                pwm_d = run_q && (cnt_q < cmp_q);
            end

            // Compare/PWM registers
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cmp_q <= '0;
                    pwm_q <= 1'b0;
                end else begin
                    cmp_q <= cmp_d;
                    pwm_q <= pwm_d;
                end
            end

            assign cmp_rd     = 32'(cmp_q);
            assign pwm_out[c] = pwm_q;
`else
            assign cmp_rd     = '0;
            assign pwm_out[c] = 1'b0;
`endif

            assign irq_ch[c] = to_q & ito_q;
            assign rd_ch[c]  = (address[2:0] == 3'd0) ? {30'b0, run_q, to_q} :
                               (address[2:0] == 3'd1) ? {30'b0, cont_q, ito_q} :
                               (address[2:0] == 3'd2) ? 32'(period_q) :
                               (address[2:0] == 3'd3) ? 32'(snap_q) :
                               (address[2:0] == 3'd4) ? cmp_rd : '0;
        end else begin : g_off
            assign rd_ch[c]  = '0;
            assign irq_ch[c] = 1'b0;
        end
    end

    assign readdata_d = (chipselect && write_n) ? rd_ch[address[4:3]] : readdata_q;

    // Registered read data, updated only on read cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_ch;
endmodule
